// File: rtl/method_sequencer.sv
// Calls up to N req/busy method units one at a time in ascending index order,
// skipping masked-off units, with a per-unit watchdog and a run cycle counter.
module method_sequencer #(
  parameter int N       = 4,
  parameter int TIMEOUT = 1024,
  parameter int IW      = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [N-1:0]  enable_mask,
  output logic [N-1:0]  unit_req,
  input  logic [N-1:0]  unit_busy,
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  done_mask,
  output logic          timeout_err,
  output logic [IW-1:0] err_index,
  output logic [31:0]   cycle_count,
  output logic [2:0]    dbg_state
);

  // Unit handshake: a one-cycle unit_req pulse launches unit idx; the unit
  // answers by raising unit_busy and signals completion by dropping it.
  // Only the selected unit's busy bit is looked at.
  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_REQ, S_WAIT_BUSY, S_WAIT_DONE, S_FINISH, S_ERROR
  } state_t;

  localparam int            TW     = $clog2(TIMEOUT);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [N-1:0]  ONE    = N'(1);
  localparam logic [IW-1:0] IDX_END = IW'(N);

  state_t        state;
  logic [IW-1:0] idx;
  logic [TW-1:0] timer;
  logic [N-1:0]  mask;
  logic [N-1:0]  sel;
  logic [N-1:0]  mask_sh;
  logic          busy_sel;

  assign sel       = ONE << idx;
  assign mask_sh   = mask >> idx;
  assign busy_sel  = |(unit_busy & sel);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      idx         <= '0;
      timer       <= '0;
      mask        <= '0;
      unit_req    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      done_mask   <= '0;
      timeout_err <= 1'b0;
      err_index   <= '0;
      cycle_count <= '0;
    end else begin
      unit_req <= '0;
      done     <= 1'b0;
      // The FINISH/ERROR cycle is the last counted one, so the value shown with done is final.
      if (state != S_IDLE && state != S_FINISH && state != S_ERROR &&
          cycle_count != 32'hFFFF_FFFF)
        cycle_count <= cycle_count + 32'd1;
      case (state)
        S_IDLE: begin
          if (start) begin
            mask        <= enable_mask;
            done_mask   <= '0;
            timeout_err <= 1'b0;
            err_index   <= '0;
            idx         <= '0;
            cycle_count <= 32'd1;
            busy        <= 1'b1;
            state       <= S_SELECT;
          end
        end
        S_SELECT: begin
          if (idx == IDX_END) begin
            done  <= 1'b1;
            state <= S_FINISH;
          end else if (!mask_sh[0]) begin
            idx <= idx + IW'(1);
          end else begin
            unit_req <= sel;
            state    <= S_REQ;
          end
        end
        S_REQ: begin
          timer <= '0;
          state <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (busy_sel) begin
            state <= S_WAIT_DONE;
          end else if (timer == T_LAST) begin
            timeout_err <= 1'b1;
            err_index   <= idx;
            done        <= 1'b1;
            state       <= S_ERROR;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_WAIT_DONE: begin
          // Completion is checked before the watchdog so a unit finishing in the last cycle succeeds.
          if (!busy_sel) begin
            done_mask <= done_mask | sel;
            idx       <= idx + IW'(1);
            state     <= S_SELECT;
          end else if (timer == T_LAST) begin
            timeout_err <= 1'b1;
            err_index   <= idx;
            done        <= 1'b1;
            state       <= S_ERROR;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_FINISH, S_ERROR: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_method_sequencer.sv
// Directed bench for method_sequencer: behavioural unit models, a scoreboard of
// expected req order and done results, and cycle-level checks on key timings.
module tb_method_sequencer;

  localparam int N = 4;
  localparam int TIMEOUT = 16;
  localparam int IW = 4;
  localparam int RW = N + 1 + IW + 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [N-1:0]  enable_mask = '0;
  logic [N-1:0]  unit_req;
  logic [N-1:0]  unit_busy = '0;
  logic          busy;
  logic          done;
  logic [N-1:0]  done_mask;
  logic          timeout_err;
  logic [IW-1:0] err_index;
  logic [31:0]   cycle_count;
  logic [2:0]    dbg_state;

  method_sequencer #(.N(N), .TIMEOUT(TIMEOUT), .IW(IW)) dut (
    .clk(clk), .reset(reset), .start(start), .enable_mask(enable_mask),
    .unit_req(unit_req), .unit_busy(unit_busy), .busy(busy), .done(done),
    .done_mask(done_mask), .timeout_err(timeout_err), .err_index(err_index),
    .cycle_count(cycle_count), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial forever #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  logic [IW-1:0] exp_req_q[$];
  logic [RW-1:0] exp_q[$];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- unit models ----------------
  int rise_d[N];
  int hold_d[N];
  int b_start[N];
  int b_end[N];
  bit armed[N];

  initial begin
    for (int i = 0; i < N; i++) begin
      armed[i] = 1'b0;
      b_start[i] = 0;
      b_end[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (busy !== 1'b1) armed[i] = 1'b0;
        if (unit_req[i] === 1'b1) begin
          armed[i] = 1'b1;
          b_start[i] = cyc + rise_d[i];
          b_end[i] = b_start[i] + hold_d[i];
        end
        unit_busy[i] = armed[i] && (cyc >= b_start[i]) && (cyc < b_end[i]);
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  function automatic logic [RW-1:0] pack(logic [N-1:0] dm, logic te,
                                         logic [IW-1:0] ei, logic [31:0] cc);
    return {dm, te, ei, cc};
  endfunction

  initial begin
    logic [N-1:0] prev_req;
    logic prev_done;
    logic [IW-1:0] ei;
    logic [RW-1:0] er;
    prev_req = '0;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (unit_req != '0) begin
          checks++;
          if ($countones(unit_req) != 1 || prev_req != '0) begin
            failures++;
            $display("FAIL req_shape: unit_req=%b prev=%b required one-hot, isolated pulse", unit_req, prev_req);
          end
          checks++;
          if (exp_req_q.size() == 0) begin
            failures++;
            $display("FAIL req_unexpected: unit_req=%b required none", unit_req);
          end else begin
            ei = exp_req_q.pop_front();
            if (unit_req != (N'(1) << ei)) begin
              failures++;
              $display("FAIL req_order: unit_req=%b required unit %0d", unit_req, ei);
            end
          end
        end
        if (prev_done) begin
          checks++;
          if (busy !== 1'b0) begin
            failures++;
            $display("FAIL busy_after_done: busy=%b required 0", busy);
          end
        end
        if (done === 1'b1) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL done_unexpected: done_mask=%b required no done", done_mask);
          end else begin
            er = exp_q.pop_front();
            if (pack(done_mask, timeout_err, err_index, cycle_count) != er) begin
              failures++;
              $display("FAIL done_result: mask=%b terr=%b eidx=%0d cc=%0d required mask=%b terr=%b eidx=%0d cc=%0d",
                       done_mask, timeout_err, err_index, cycle_count,
                       er[RW-1 -: N], er[IW+32], er[IW+31 -: IW], er[31:0]);
            end
          end
        end
        prev_req = unit_req;
        prev_done = done;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic set_units(input int rise, input int hold);
    for (int i = 0; i < N; i++) begin
      rise_d[i] = rise;
      hold_d[i] = hold;
    end
  endtask

  // Returns in the first cycle after the accepting edge.
  task automatic pulse_start(input logic [N-1:0] m);
    enable_mask = m;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    for (int i = 0; i < budget && busy === 1'b1; i++) tick(1);
    check(name, 64'(busy), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    set_units(1, 3);
    tick(3);
    check("reset_outputs", 64'({unit_req, busy, done, done_mask, timeout_err, err_index, dbg_state}), 64'd0);
    check("reset_cycle_count", 64'(cycle_count), 64'd0);
    reset = 1'b0;
    tick(1);
    mon_en = 1'b1;

    // All four units, rise 1, hold 3: 4*6 + 2 cycles.
    for (int i = 0; i < N; i++) exp_req_q.push_back(IW'(i));
    exp_q.push_back(pack(4'b1111, 1'b0, 4'd0, 32'd26));
    pulse_start(4'b1111);
    check("busy_after_start", 64'(busy), 64'd1);
    tick(1);
    check("first_req_timing", 64'(unit_req), 64'b0001);
    wait_idle("run_all_idle", 200);
    tick(3);
    check("cycle_count_held", 64'(cycle_count), 64'd26);

    // Empty mask: busy cycles 1..6, done at cycle 6.
    exp_q.push_back(pack(4'b0000, 1'b0, 4'd0, 32'd6));
    pulse_start(4'b0000);
    for (int j = 1; j <= 6; j++) begin
      check("empty_busy", 64'(busy), 64'd1);
      check("empty_done", 64'(done), 64'(j == 6));
      tick(1);
    end
    check("empty_idle", 64'(busy), 64'd0);

    // Sparse mask.
    exp_req_q.push_back(4'd1);
    exp_req_q.push_back(4'd3);
    exp_q.push_back(pack(4'b1010, 1'b0, 4'd0, 32'd16));
    pulse_start(4'b1010);
    wait_idle("sparse_idle", 200);

    // Unit 2 never answers: 12 + 1 + 1 + 16 + 1 cycles.
    rise_d[2] = 100000;
    for (int i = 0; i < 3; i++) exp_req_q.push_back(IW'(i));
    exp_q.push_back(pack(4'b0011, 1'b1, 4'd2, 32'd31));
    pulse_start(4'b1111);
    wait_idle("timeout_idle", 300);
    tick(2);
    check("timeout_sticky", 64'({timeout_err, err_index}), 64'h12);
    set_units(1, 3);
    exp_req_q.push_back(4'd0);
    exp_q.push_back(pack(4'b0001, 1'b0, 4'd0, 32'd11));
    pulse_start(4'b0001);
    check("timeout_cleared", 64'({timeout_err, err_index}), 64'h00);
    wait_idle("after_timeout_idle", 200);

    // Start while busy and start coincident with done are both ignored.
    exp_req_q.push_back(4'd0);
    exp_q.push_back(pack(4'b0001, 1'b0, 4'd0, 32'd11));
    pulse_start(4'b0001);
    tick(2);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    for (int i = 0; i < 100 && done !== 1'b1; i++) tick(1);
    check("ignore_done_seen", 64'(done), 64'd1);
    enable_mask = 4'b1111;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("ignore_no_rerun", 64'(busy), 64'd0);
    tick(5);
    check("ignore_still_idle", 64'(busy), 64'd0);

    // Reset during WAIT_DONE of unit 1.
    exp_req_q.push_back(4'd0);
    exp_req_q.push_back(4'd1);
    pulse_start(4'b1111);
    for (int i = 0; i < 100 && unit_req[1] !== 1'b1; i++) tick(1);
    check("reset_run_req1", 64'(unit_req), 64'b0010);
    tick(2);
    check("reset_run_in_wait_done", 64'(dbg_state), 64'd4);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("midrun_reset_outputs", 64'({unit_req, busy, done, done_mask, timeout_err, err_index, dbg_state}), 64'd0);
    check("midrun_reset_cycle_count", 64'(cycle_count), 64'd0);
    tick(20);
    check("midrun_reset_stays_idle", 64'(busy), 64'd0);

    // Watchdog boundary: busy falling in the last allowed cycle still succeeds.
    rise_d[0] = 1;
    hold_d[0] = TIMEOUT - 1;
    exp_req_q.push_back(4'd0);
    exp_q.push_back(pack(4'b0001, 1'b0, 4'd0, 32'd23));
    pulse_start(4'b0001);
    wait_idle("prio_a_idle", 200);
    hold_d[0] = TIMEOUT;
    exp_req_q.push_back(4'd0);
    exp_q.push_back(pack(4'b0001, 1'b0, 4'd0, 32'd24));
    pulse_start(4'b0001);
    wait_idle("prio_b_idle", 200);

    tick(3);
    check("req_queue_empty", 64'(exp_req_q.size()), 64'd0);
    check("done_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/method_sequencer.md
# method_sequencer

Sequencer for Synthesijer-generated method units that share the req/busy call handshake. On one `start` pulse it calls up to N units strictly one at a time, in ascending index order, skipping units disabled in a mask. It reports completion, per-unit done flags, a watchdog timeout and the total cycle count. It sits between a top-level driver (bench counter or host logic) and the `*_req`/`*_busy` ports of the units it launches, replacing hand-wired shared `req` nets.

## Interface
Parameters:
- N, 4, number of sequenced units (1..16)
- TIMEOUT, 1024, max cycles spent waiting on one unit (both busy-rise and busy-fall phases together); must be ≥ 2
- IW, 4, index width; must satisfy 2^IW > N

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- start  in  1  launch request; honoured only in IDLE
- enable_mask  in  N  bit i=1 calls unit i; sampled on accepted start
- unit_req  out  N  one-hot call pulse to unit i
- unit_busy  in  N  busy from unit i
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of a run (success or error)
- done_mask  out  N  bit i set when unit i completed in this run
- timeout_err  out  1  sticky error flag, cleared on next accepted start
- err_index  out  IW  index of the unit that timed out
- cycle_count  out  32  cycles from accepted start to done inclusive, held after done

## Operation
- All outputs are registered (Moore). Reset values: all outputs 0; state IDLE; idx 0; timer 0.
- States: IDLE, SELECT, REQ, WAIT_BUSY, WAIT_DONE, FINISH, ERROR.
- IDLE:
  - start=1 → latch enable_mask; clear done_mask, timeout_err, err_index, idx; set cycle_count=1; go to SELECT.
  - start=0 → stay in IDLE.
- SELECT:
  - idx==N → FINISH.
  - mask[idx]==0 → idx+1, stay in SELECT.
  - otherwise → REQ.
- REQ:
  - unit_req[idx]=1 for exactly this cycle; timer cleared; → WAIT_BUSY.
- WAIT_BUSY:
  - unit_busy[idx]=1 → WAIT_DONE.
  - otherwise timer+1.
- WAIT_DONE:
  - unit_busy[idx]=0 → set done_mask[idx]; idx+1; → SELECT.
  - otherwise timer+1.
- Timeout: in WAIT_BUSY or WAIT_DONE, if timer reaches TIMEOUT-1 without the exit condition → ERROR. The exit condition has priority over timeout when both occur in the same cycle.
- ERROR:
  - Set timeout_err=1 and err_index=idx.
  - done=1 for this cycle.
  - → IDLE. Remaining units are not called.
- FINISH: done=1 for this cycle; → IDLE.
- cycle_count increments by 1 in every non-IDLE cycle; saturates at 0xFFFFFFFF.
- start asserted in any state other than IDLE is ignored and not queued. start in the same cycle as done is also ignored; the unit is in FINISH/ERROR that cycle.
- unit_busy bits of non-selected units are ignored.
- Reset mid-run: on the next edge, state returns to IDLE and all outputs (including unit_req) return to 0. No further req is issued.

## Timing
- Accepted start at edge k:
  - busy=1 from k+1.
  - First SELECT at k+1.
  - First unit_req at k+2 at the earliest (mask bit 0 set).
- Each disabled unit costs one SELECT cycle.
- Per enabled unit: 1 SELECT + 1 REQ + B_rise cycles in WAIT_BUSY + B_high cycles in WAIT_DONE.
- Unit turnaround: unit_req for the next unit comes no sooner than 2 cycles after the previous unit_busy falls.
- unit_req is never high for two consecutive cycles; at most one bit is ever set.
- done and busy fall together: busy=0 in the cycle after done.

## Test plan
- N=4, mask=4'b1111, each model raises busy 1 cycle after req and holds it 3 cycles → four single-cycle req pulses in order 0..3; done_mask=4'b1111; timeout_err=0; exactly one done pulse.
- mask=4'b0000, start at cycle 0 → busy cycles 1–6, done at cycle 6, cycle_count=6, no unit_req ever.
- mask=4'b1010 → only unit_req[1] and unit_req[3] pulse; done_mask=4'b1010.
- TIMEOUT=16, unit 2 never raises busy → ERROR; timeout_err=1; err_index=2; done_mask=4'b0011; unit 3 never requested; next start clears timeout_err.
- start re-pulsed while busy, plus a start coincident with done → ignored, no second run. Reset asserted during WAIT_DONE of unit 1 → all outputs 0 next cycle, no further req.
- Unit busy held for exactly TIMEOUT-1 cycles, falling in the timeout cycle → success, not error (priority check).
